// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
// Holds the table geometry, 2-bit counter encodings and PC field helpers.
package arm_bp_pkg;

  localparam int BTB_ENTRIES = 16;
  localparam int IDX_W       = 4;
  localparam int TAG_W       = 26;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    ctr_e             ctr;
  } btb_entry_t;

  // Word-aligned PCs: index skips the two byte-offset bits.
  function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
    return pc[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
    return pc[31:IDX_W+2];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and E2 resolve signals of the branch predictor.
// Valid/ready: no backpressure; ValidE2 qualifies E2 inputs each cycle, outputs are combinational.
interface bp_if;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] NextPCF;
  logic        ValidE2;
  logic        BranchE2;
  logic        ActualTakenE2;
  logic [31:0] PCE2;
  logic [31:0] BranchTargetE2;
  logic        PredTakenE2;
  logic [31:0] PredTargetE2;
  logic        BranchCorrect;
  logic        RedirectE2;
  logic [31:0] RedirectPCE2;
  logic [15:0] BranchCount;
  logic [15:0] MispredictCount;

  modport master (
    output PCF, ValidE2, BranchE2, ActualTakenE2, PCE2, BranchTargetE2,
           PredTakenE2, PredTargetE2,
    input  PredTakenF, NextPCF, BranchCorrect, RedirectE2, RedirectPCE2,
           BranchCount, MispredictCount
  );

  modport slave (
    input  PCF, ValidE2, BranchE2, ActualTakenE2, PCE2, BranchTargetE2,
           PredTakenE2, PredTargetE2,
    output PredTakenF, NextPCF, BranchCorrect, RedirectE2, RedirectPCE2,
           BranchCount, MispredictCount
  );
endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_ctr
  import arm_bp_pkg::*;
(
  input  ctr_e ctr,
  input  logic taken,
  output ctr_e next_ctr
);

  always_comb begin
    next_ctr = ctr;
    case (ctr)
      SNT: next_ctr = taken ? WNT : SNT;
      WNT: next_ctr = taken ? WT  : SNT;
      WT:  next_ctr = taken ? ST  : WNT;
      ST:  next_ctr = taken ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// 16-entry direct-mapped BTB with 2-bit counters: combinational fetch lookup,
// E2 resolve/mispredict detection, table training and saturating perf counters.
module branch_predictor
  import arm_bp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  bp_if.slave  bus
);

  btb_entry_t btb [BTB_ENTRIES];

  btb_entry_t       lk_entry;
  btb_entry_t       up_entry;
  logic [IDX_W-1:0] up_idx;
  logic             lk_hit;
  logic             up_tag_match;
  logic             up_hit;
  logic             mispredict;
  ctr_e             up_ctr_next;
  logic [15:0]      branch_cnt;
  logic [15:0]      mispredict_cnt;

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign lk_entry = btb[pc_idx(bus.PCF)];
  assign lk_hit   = lk_entry.valid && (lk_entry.tag == pc_tag(bus.PCF));

  assign bus.PredTakenF = lk_hit && lk_entry.ctr[1];
  assign bus.NextPCF    = bus.PredTakenF ? lk_entry.target : bus.PCF + 32'd4;

  assign up_idx       = pc_idx(bus.PCE2);
  assign up_entry     = btb[up_idx];
  assign up_tag_match = (up_entry.tag == pc_tag(bus.PCE2));
  assign up_hit       = up_entry.valid && up_tag_match;

  // A non-branch predicted taken means a BTB alias steered fetch wrongly.
  always_comb begin
    mispredict = 1'b0;
    if (bus.ValidE2) begin
      if (bus.BranchE2)
        mispredict = (bus.PredTakenE2 != bus.ActualTakenE2) ||
                     (bus.PredTakenE2 && bus.ActualTakenE2 &&
                      (bus.PredTargetE2 != bus.BranchTargetE2));
      else
        mispredict = bus.PredTakenE2;
    end
  end

  assign bus.BranchCorrect   = !mispredict;
  assign bus.RedirectE2      = mispredict;
  assign bus.RedirectPCE2    = (bus.ActualTakenE2 && bus.BranchE2) ?
                               bus.BranchTargetE2 : bus.PCE2 + 32'd4;
  assign bus.BranchCount     = branch_cnt;
  assign bus.MispredictCount = mispredict_cnt;

  bp_sat_ctr u_sat_ctr (
    .ctr      (up_entry.ctr),
    .taken    (bus.ActualTakenE2),
    .next_ctr (up_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (bus.ValidE2) begin
      if (bus.BranchE2) begin
        if (up_hit) begin
          btb[up_idx].ctr <= up_ctr_next;
          if (bus.ActualTakenE2) btb[up_idx].target <= bus.BranchTargetE2;
        end else if (bus.ActualTakenE2) begin
          btb[up_idx] <= '{valid: 1'b1, tag: pc_tag(bus.PCE2),
                           target: bus.BranchTargetE2, ctr: WT};
        end
        if (branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
      end else if (bus.PredTakenE2 && up_tag_match) begin
        btb[up_idx].valid <= 1'b0;
      end
      if (mispredict && (mispredict_cnt != 16'hFFFF))
        mispredict_cnt <= mispredict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset-override sequence,
// random traffic against an array-based reference model, counter saturation.
module tb_branch_predictor;

  localparam int W = 67;

  typedef struct {
    logic [31:0] pcf;
    logic        valid;
    logic        branch;
    logic        taken;
    logic [31:0] pce2;
    logic [31:0] bt;
    logic        pred_t;
    logic [31:0] pred_tgt;
    logic        exp_pt;
    logic [31:0] exp_npc;
    logic        exp_bc;
    logic [31:0] exp_rpc;
    logic [15:0] exp_bcnt;
    logic [15:0] exp_mcnt;
  } vec_t;

  logic clk;
  logic reset;
  bp_if bus ();

  branch_predictor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];
  vec_t vecs[$];

  // Reference model state: one slot per BTB index, counters as plain integers.
  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  int          m_bcnt;
  int          m_mcnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hF);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  task automatic model_commit();
    int i;
    bit hit, misp;
    if (!reset) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = 1;
      end
      m_bcnt = 0;
      m_mcnt = 0;
      return;
    end
    if (!bus.ValidE2) return;
    i = idx_of(bus.PCE2);
    hit = m_valid[i] && (m_tag[i] == tag_of(bus.PCE2));
    if (bus.BranchE2) begin
      misp = (bus.PredTakenE2 != bus.ActualTakenE2) ||
             (bus.PredTakenE2 && bus.ActualTakenE2 && bus.PredTargetE2 != bus.BranchTargetE2);
      if (hit && bus.ActualTakenE2) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_target[i] = bus.BranchTargetE2;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end else if (bus.ActualTakenE2) begin
        m_valid[i] = 1; m_tag[i] = tag_of(bus.PCE2);
        m_target[i] = bus.BranchTargetE2; m_ctr[i] = 2;
      end
      if (m_bcnt < 65535) m_bcnt++;
    end else begin
      misp = bus.PredTakenE2;
      if (bus.PredTakenE2 && m_tag[i] == tag_of(bus.PCE2)) m_valid[i] = 0;
    end
    if (misp && m_mcnt < 65535) m_mcnt++;
  endtask

  function automatic bit model_pred(input logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] pc);
    return model_pred(pc) ? m_target[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic drive(input logic rst_n, input logic [31:0] pcf, input logic v,
                       input logic b, input logic t, input logic [31:0] pce2,
                       input logic [31:0] bt, input logic pt, input logic [31:0] ptgt);
    reset = rst_n;
    bus.PCF = pcf; bus.ValidE2 = v; bus.BranchE2 = b; bus.ActualTakenE2 = t;
    bus.PCE2 = pce2; bus.BranchTargetE2 = bt; bus.PredTakenE2 = pt; bus.PredTargetE2 = ptgt;
  endtask

  // Scoreboard: expected combinational outputs from the model, then compare.
  task automatic check_model();
    logic [W-1:0] e;
    bit misp;
    logic [31:0] rpc;
    if (bus.BranchE2)
      misp = bus.ValidE2 && ((bus.PredTakenE2 != bus.ActualTakenE2) ||
             (bus.PredTakenE2 && bus.ActualTakenE2 && bus.PredTargetE2 != bus.BranchTargetE2));
    else
      misp = bus.ValidE2 && bus.PredTakenE2;
    rpc = (bus.ActualTakenE2 && bus.BranchE2) ? bus.BranchTargetE2 : bus.PCE2 + 32'd4;
    exp_q.push_back({model_pred(bus.PCF), model_npc(bus.PCF), !misp, misp, rpc});
    e = exp_q.pop_front();
    chk("pred_taken_f", {31'd0, bus.PredTakenF}, {31'd0, e[66]});
    chk("next_pc_f", bus.NextPCF, e[65:34]);
    chk("branch_correct", {31'd0, bus.BranchCorrect}, {31'd0, e[33]});
    chk("redirect_e2", {31'd0, bus.RedirectE2}, {31'd0, e[32]});
    chk("redirect_pc_e2", bus.RedirectPCE2, e[31:0]);
    chk("branch_count", {16'd0, bus.BranchCount}, m_bcnt);
    chk("mispredict_count", {16'd0, bus.MispredictCount}, m_mcnt);
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic add(input logic [31:0] pcf, input logic v, input logic b, input logic t,
                     input logic [31:0] pce2, input logic [31:0] bt, input logic pt,
                     input logic [31:0] ptgt, input logic ept, input logic [31:0] enpc,
                     input logic ebc, input logic [31:0] erpc, input logic [15:0] ebcnt,
                     input logic [15:0] emcnt);
    vec_t r;
    r.pcf = pcf; r.valid = v; r.branch = b; r.taken = t; r.pce2 = pce2; r.bt = bt;
    r.pred_t = pt; r.pred_tgt = ptgt; r.exp_pt = ept; r.exp_npc = enpc; r.exp_bc = ebc;
    r.exp_rpc = erpc; r.exp_bcnt = ebcnt; r.exp_mcnt = emcnt;
    vecs.push_back(r);
  endtask

  initial begin
    logic [31:0] pc, pc2, tgt;
    logic b, t, pt;
    checks = 0;
    failures = 0;

    // pcf v b t pce2 bt pt ptgt | pt npc bc rpc bcnt mcnt
    add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 1, 32'h4,   0, 0);
    add(32'h100, 1,1,1, 32'h100, 32'h200, 0, 32'h0,   0, 32'h104, 0, 32'h200, 0, 0);
    add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h200, 1, 32'h4,   1, 1);
    add(32'h100, 1,1,0, 32'h100, 32'h200, 1, 32'h200, 1, 32'h200, 0, 32'h104, 1, 1);
    add(32'h100, 1,1,0, 32'h100, 32'h200, 0, 32'h0,   0, 32'h104, 1, 32'h104, 2, 2);
    add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 1, 32'h4,   3, 2);
    add(32'h140, 1,1,1, 32'h140, 32'h300, 0, 32'h0,   0, 32'h144, 0, 32'h300, 3, 2);
    add(32'h100, 1,1,1, 32'h100, 32'h200, 0, 32'h0,   0, 32'h104, 0, 32'h200, 4, 3);
    add(32'h100, 1,0,0, 32'h100, 32'h0,   1, 32'h200, 1, 32'h200, 0, 32'h104, 5, 4);
    add(32'h100, 1,0,0, 32'h140, 32'h0,   1, 32'h200, 0, 32'h104, 0, 32'h144, 5, 5);
    add(32'h140, 0,1,0, 32'h100, 32'h0,   1, 32'h0,   0, 32'h144, 1, 32'h104, 5, 6);
    add(32'hFFFFFFFC, 0,0,0, 32'hFFFFFFFC, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 5, 6);
    add(32'h100, 1,1,1, 32'h100, 32'h200, 1, 32'h250, 0, 32'h104, 0, 32'h200, 5, 6);
    add(32'h100, 1,1,1, 32'h100, 32'h200, 1, 32'h200, 1, 32'h200, 1, 32'h200, 6, 7);
    add(32'h100, 1,1,1, 32'h100, 32'h200, 1, 32'h200, 1, 32'h200, 1, 32'h200, 7, 7);
    add(32'h100, 1,1,1, 32'h100, 32'h280, 1, 32'h200, 1, 32'h200, 0, 32'h280, 8, 7);
    add(32'h100, 0,0,0, 32'h0,   32'h0,   0, 32'h0,   1, 32'h280, 1, 32'h4,   9, 8);

    @(negedge clk);
    // Reset with a taken branch presented: reset wins, lookups see a cleared table.
    drive(0, 32'h100, 1, 1, 1, 32'h100, 32'h200, 0, 32'h0);
    advance();
    drive(0, 32'h100, 1, 1, 1, 32'h100, 32'h200, 0, 32'h0);
    #2;
    chk("rst_pred_taken", {31'd0, bus.PredTakenF}, 32'd0);
    chk("rst_next_pc", bus.NextPCF, 32'h104);
    chk("rst_branch_count", {16'd0, bus.BranchCount}, 32'd0);
    chk("rst_mispredict_count", {16'd0, bus.MispredictCount}, 32'd0);
    advance();

    foreach (vecs[k]) begin
      drive(1, vecs[k].pcf, vecs[k].valid, vecs[k].branch, vecs[k].taken, vecs[k].pce2,
            vecs[k].bt, vecs[k].pred_t, vecs[k].pred_tgt);
      #2;
      chk($sformatf("vec%0d_pred_taken", k), {31'd0, bus.PredTakenF}, {31'd0, vecs[k].exp_pt});
      chk($sformatf("vec%0d_next_pc", k), bus.NextPCF, vecs[k].exp_npc);
      chk($sformatf("vec%0d_branch_correct", k), {31'd0, bus.BranchCorrect}, {31'd0, vecs[k].exp_bc});
      chk($sformatf("vec%0d_redirect", k), {31'd0, bus.RedirectE2}, {31'd0, !vecs[k].exp_bc});
      chk($sformatf("vec%0d_redirect_pc", k), bus.RedirectPCE2, vecs[k].exp_rpc);
      chk($sformatf("vec%0d_branch_count", k), {16'd0, bus.BranchCount}, {16'd0, vecs[k].exp_bcnt});
      chk($sformatf("vec%0d_mispredict_count", k), {16'd0, bus.MispredictCount}, {16'd0, vecs[k].exp_mcnt});
      advance();
    end

    // Mid-run reset with an allocating update pending must leave the table empty.
    drive(0, 32'h100, 1, 1, 1, 32'h100, 32'h200, 0, 32'h0);
    advance();
    drive(1, 32'h100, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    chk("reset_override_pred", {31'd0, bus.PredTakenF}, 32'd0);
    chk("reset_override_bcnt", {16'd0, bus.BranchCount}, 32'd0);
    advance();

    // Random traffic over a small PC pool so hits, aliases and evictions are common.
    for (int n = 0; n < 2000; n++) begin
      pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      pc2 = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      tgt = $urandom_range(0, 7) << 8;
      b = ($urandom_range(0, 3) != 0);
      t = $urandom_range(0, 1);
      pt = ($urandom_range(0, 1) != 0) ? model_pred(pc2) : 1'($urandom_range(0, 1));
      drive(($urandom_range(0, 99) != 0), pc, ($urandom_range(0, 4) != 0), b, t, pc2, tgt, pt,
            ($urandom_range(0, 1) != 0) ? model_npc(pc2) : tgt);
      #2;
      check_model();
      advance();
    end

    // Counter saturation: mispredicted not-taken branches that never allocate.
    drive(0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    advance();
    for (int n = 0; n < 65534; n++) begin
      drive(1, 32'h0, 1, 1, 0, 32'h100, 32'h0, 1, 32'h200);
      advance();
    end
    #2;
    chk("sat_bcnt_fffe", {16'd0, bus.BranchCount}, 32'hFFFE);
    chk("sat_mcnt_fffe", {16'd0, bus.MispredictCount}, 32'hFFFE);
    for (int n = 0; n < 3; n++) begin
      drive(1, 32'h0, 1, 1, 0, 32'h100, 32'h0, 1, 32'h200);
      #2;
      check_model();
      advance();
    end
    drive(1, 32'h0, 0, 1, 0, 32'h100, 32'h0, 1, 32'h200);
    #2;
    chk("sat_bcnt_ffff", {16'd0, bus.BranchCount}, 32'hFFFF);
    chk("sat_mcnt_ffff", {16'd0, bus.MispredictCount}, 32'hFFFF);
    chk("invalid_branch_correct", {31'd0, bus.BranchCorrect}, 32'd1);
    advance();
    #2;
    chk("invalid_no_count", {16'd0, bus.MispredictCount}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port PCF, input, 32, fetch-stage PC used for lookup.
REQ-004 SHALL have port PredTakenF, output, 1, fetch prediction "taken".
REQ-005 SHALL have port NextPCF, output, 32, predicted next fetch PC.
REQ-006 SHALL have port ValidE2, input, 1, E2 holds a live instruction (not flushed, not bubble).
REQ-007 SHALL have port BranchE2, input, 1, E2 instruction is a branch.
REQ-008 SHALL have port ActualTakenE2, input, 1, resolved direction (condition passed).
REQ-009 SHALL have ports PCE2 and BranchTargetE2, input, 32 each, resolved branch PC and target.
REQ-010 SHALL have ports PredTakenE2 (1) and PredTargetE2 (32), input, fetch prediction carried down the pipe.
REQ-011 SHALL have port BranchCorrect, output, 1, E2 prediction matched outcome; feeds hazard unit.
REQ-012 SHALL have ports RedirectE2 (1) and RedirectPCE2 (32), output, fetch redirect request and address.
REQ-013 SHALL have ports BranchCount and MispredictCount, output, 16 each, performance counters.

Function
REQ-014 SHALL hold a 16-entry direct-mapped BTB; index PC[5:2], tag PC[31:6]; entry = valid, tag, 32-bit target, 2-bit saturating counter.
REQ-015 Lookup SHALL be combinational on PCF: hit = valid & tag match; PredTakenF = hit & ctr[1]; NextPCF = PredTakenF ? target : PCF+4.
REQ-016 Mispredict SHALL be computed combinationally when ValidE2: branch with PredTakenE2 != ActualTakenE2; or branch with both taken and PredTargetE2 != BranchTargetE2; or non-branch with PredTakenE2=1 (alias).
REQ-017 BranchCorrect SHALL be ~mispredict; SHALL be 1 when ValidE2=0.
REQ-018 RedirectE2 SHALL equal mispredict; RedirectPCE2 = ActualTakenE2&BranchE2 ? BranchTargetE2 : PCE2+4.
REQ-019 Branch update, hit at PCE2: taken -> ctr+1 saturating at 11, target rewritten; not-taken -> ctr-1 saturating at 00.
REQ-020 Branch update, miss: taken -> allocate (valid=1, tag, target, ctr=10), overwriting any occupant; not-taken -> no write.
REQ-021 Non-branch with PredTakenE2=1 SHALL clear valid of the entry indexed by PCE2 if tag matches.
REQ-022 No table or counter update SHALL occur when ValidE2=0.
REQ-023 Same-cycle lookup and update to the same index SHALL return pre-update contents (no bypass); new contents visible next cycle.
REQ-024 BranchCount SHALL increment on each ValidE2&BranchE2; MispredictCount on each mispredict; both saturate at 16'hFFFF.
REQ-025 PC arithmetic SHALL be modulo 2^32 (PCF=32'hFFFFFFFC -> PCF+4=0).

Reset
REQ-026 While reset=0 at a clock edge: all valid bits 0, counters 01, targets/tags 0, BranchCount=0, MispredictCount=0.
REQ-027 Reset SHALL override a same-cycle update; outputs during reset follow combinational rules on the cleared table (PredTakenF=0, NextPCF=PCF+4).

Structure
REQ-028 Package arm_bp_pkg SHALL hold BTB_ENTRIES=16, IDX_W=4, TAG_W=26, counter encodings SNT=00, WNT=01, WT=10, ST=11.
REQ-029 Saturating 2-bit update SHALL be one sub-module bp_sat_ctr (inputs ctr, taken; output next ctr); table and counters stay in branch_predictor.

Verification
REQ-030 After reset, PCF=0x100 -> PredTakenF=0, NextPCF=0x104; counters 0.
REQ-031 Taken branch PCE2=0x100, target 0x200, ValidE2=1, PredTakenE2=0 -> BranchCorrect=0, RedirectPCE2=0x200; next cycle PCF=0x100 -> PredTakenF=1, NextPCF=0x200; MispredictCount=1.
REQ-032 Same branch resolved not-taken twice -> ctr 10->01->00; PCF=0x100 -> PredTakenF=0; second resolve with PredTakenE2=0 -> BranchCorrect=1.
REQ-033 Entry at 0x100 (ctr 10); non-branch PCE2=0x100 with PredTakenE2=1 -> BranchCorrect=0, RedirectPCE2=0x104, entry invalidated; alias PC 0x140 never hits.
REQ-034 Lookup PCF=0x100 in same cycle as allocating update at 0x100 -> PredTakenF=0 that cycle, 1 the next.
REQ-035 Preload MispredictCount=0xFFFE, issue 3 mispredicts -> 0xFFFF held; ValidE2=0 mispredict pattern -> no count, BranchCorrect=1.
